// File: rtl/ahb2apb_bridge_pkg.sv
// Shared AHB/APB codes and bridge state encoding.
// Imported by the bridge RTL and the testbench.
package ahb2apb_bridge_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  // Widest transfer size the 32-bit APB side can carry.
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } state_e;

  function automatic logic trans_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb2apb_bridge_if.sv
// AHB slave port plus APB master port of the bridge, bundled as one interface.
// The slave modport is the bridge's view; master is the environment's.
interface ahb2apb_bridge_if #(
  parameter int NUM_PSEL = 4
);
  logic                hsel_i;
  logic [31:0]         haddr_i;
  logic [1:0]          htrans_i;
  logic                hwrite_i;
  logic [2:0]          hsize_i;
  logic [31:0]         hwdata_i;
  logic                hready_i;
  logic                hready_o;
  logic [1:0]          hresp_o;
  logic [31:0]         hrdata_o;

  logic [15:0]         paddr_o;
  logic [NUM_PSEL-1:0] psel_o;
  logic                penable_o;
  logic                pwrite_o;
  logic [31:0]         pwdata_o;
  logic [31:0]         prdata_i;
  logic                pready_i;
  logic                pslverr_i;

  modport slave (
    input  hsel_i, haddr_i, htrans_i, hwrite_i, hsize_i, hwdata_i, hready_i,
    output hready_o, hresp_o, hrdata_o,
    output paddr_o, psel_o, penable_o, pwrite_o, pwdata_o,
    input  prdata_i, pready_i, pslverr_i
  );

  modport master (
    output hsel_i, haddr_i, htrans_i, hwrite_i, hsize_i, hwdata_i, hready_i,
    input  hready_o, hresp_o, hrdata_o,
    input  paddr_o, psel_o, penable_o, pwrite_o, pwdata_o,
    output prdata_i, pready_i, pslverr_i
  );
endinterface

// File: rtl/ahb2apb_bridge_apb_wdog.sv
// ACCESS-phase wait counter; flags expiry on the TIMEOUT-th stalled cycle.
module apb_wdog #(
  parameter int TIMEOUT = 255
) (
  input  logic hclk,
  input  logic hreset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  logic [7:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset)        r_cnt <= '0;
    else if (i_clear)  r_cnt <= '0;
    else if (i_enable) r_cnt <= r_cnt + 8'd1;
  end

  assign o_expired = i_enable && (r_cnt == 8'(TIMEOUT - 1));
endmodule

// File: rtl/ahb2apb_bridge.sv
// AHB-Lite slave to APB master bridge: one APB transfer per AHB transfer,
// with illegal-decode, PSLVERR and ACCESS-timeout mapped to a two-cycle ERROR.
module ahb2apb_bridge
  import ahb2apb_bridge_pkg::*;
#(
  parameter int NUM_PSEL = 4,
  parameter int TIMEOUT  = 255
) (
  input logic             hclk,
  input logic             hreset,
  ahb2apb_bridge_if.slave bus
);
  state_e              r_state, w_next;
  logic [15:0]         r_paddr;
  logic                r_write;
  logic [NUM_PSEL-1:0] r_psel;
  logic                r_illegal;
  logic [31:0]         r_pwdata;
  logic [31:0]         r_hrdata;

  logic [3:0]          w_index;
  logic [NUM_PSEL-1:0] w_psel_dec;
  logic                w_illegal;
  logic                w_start;
  logic                w_capture;
  logic                w_wdog_clear;
  logic                w_wdog_en;
  logic                w_expired;
  logic                w_unused;

  assign w_unused  = ^bus.haddr_i[31:16];
  assign w_index   = bus.haddr_i[15:12];
  assign w_illegal = (32'(w_index) >= NUM_PSEL) || (bus.hsize_i > HSIZE_WORD);
  assign w_start   = bus.hsel_i && bus.hready_i && trans_active(bus.htrans_i);
  assign w_capture = ((r_state == ST_IDLE) || (r_state == ST_ERR2)) && w_start;

  always_comb begin
    w_psel_dec = '0;
    for (int i = 0; i < NUM_PSEL; i++) w_psel_dec[i] = !w_illegal && (w_index == 4'(i));
  end

  apb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .hclk     (hclk),
    .hreset   (hreset),
    .i_clear  (w_wdog_clear),
    .i_enable (w_wdog_en),
    .o_expired(w_expired)
  );

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_next       = r_state;
    w_wdog_clear = 1'b0;
    w_wdog_en    = 1'b0;
    case (r_state)
      ST_IDLE:   if (w_start) w_next = ST_LATCH;
      ST_LATCH:  w_next = r_illegal ? ST_ERR1 : ST_SETUP;
      ST_SETUP: begin
        w_next       = ST_ACCESS;
        w_wdog_clear = 1'b1;
      end
      ST_ACCESS: begin
        if (bus.pready_i) begin
          w_next = bus.pslverr_i ? ST_ERR1 : ST_IDLE;
        end else begin
          w_wdog_en = 1'b1;
          if (w_expired) w_next = ST_ERR1;
        end
      end
      ST_ERR1:   w_next = ST_ERR2;
      ST_ERR2:   w_next = w_start ? ST_LATCH : ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_paddr   <= '0;
      r_write   <= 1'b0;
      r_psel    <= '0;
      r_illegal <= 1'b0;
      r_pwdata  <= '0;
      r_hrdata  <= '0;
    end else begin
      if (w_capture) begin
        r_paddr   <= bus.haddr_i[15:0];
        r_write   <= bus.hwrite_i;
        r_psel    <= w_psel_dec;
        r_illegal <= w_illegal;
      end
      if ((r_state == ST_LATCH) && r_write) r_pwdata <= bus.hwdata_i;
      // Only a clean read updates the read-data holding register.
      if ((r_state == ST_ACCESS) && bus.pready_i && !bus.pslverr_i && !r_write)
        r_hrdata <= bus.prdata_i;
    end
  end

  // Bus outputs are pure state decodes, so reset forces them immediately.
  assign bus.hready_o  = !((r_state == ST_LATCH) || (r_state == ST_SETUP) ||
                           (r_state == ST_ACCESS) || (r_state == ST_ERR1));
  assign bus.hresp_o   = ((r_state == ST_ERR1) || (r_state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign bus.hrdata_o  = r_hrdata;
  assign bus.paddr_o   = r_paddr;
  assign bus.psel_o    = ((r_state == ST_SETUP) || (r_state == ST_ACCESS)) ? r_psel : '0;
  assign bus.penable_o = (r_state == ST_ACCESS);
  assign bus.pwrite_o  = r_write;
  assign bus.pwdata_o  = r_pwdata;
endmodule
